// File: rtl/pid_engine_mc_if.sv
// Measurement, configuration and result bundle for pid_engine_mc.
// master = requester / configurator side, slave = the engine.
interface pid_engine_mc_if #(
    parameter int N_CH = 4,
    parameter int W    = 14
);
    localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                  meas_vld;
    logic [CHW-1:0]        meas_ch;
    logic signed [W-1:0]   meas;
    logic                  meas_rdy;
    logic                  cfg_we;
    logic [CHW-1:0]        cfg_ch;
    logic [2:0]            cfg_sel;
    logic signed [W-1:0]   cfg_data;
    logic                  duty_vld;
    logic [CHW-1:0]        duty_ch;
    logic signed [W-1:0]   duty;
    logic                  ch_err;
    logic                  busy;

    modport master (
        output meas_vld, meas_ch, meas, cfg_we, cfg_ch, cfg_sel, cfg_data,
        input  meas_rdy, duty_vld, duty_ch, duty, ch_err, busy
    );

    modport slave (
        input  meas_vld, meas_ch, meas, cfg_we, cfg_ch, cfg_sel, cfg_data,
        output meas_rdy, duty_vld, duty_ch, duty, ch_err, busy
    );
endinterface

// File: rtl/pid_engine_mc.sv
// Multi-channel PID engine: per-channel setpoint/gains/loop state, one shared
// sequential radix-2 Booth multiplier for the P, I and D products.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for a measurement (meas_rdy=1)
// ERR    | form saturated error, integrator sum and derivative
// PMUL   | W Booth steps of Kp * err
// IMUL   | W Booth steps of Ki * sum
// DMUL   | W Booth steps of Kd * derr
// OUT    | saturate P+I+D into duty, write back SumErr/PrevErr
module pid_engine_mc #(
    parameter int N_CH = 4,
    parameter int W    = 14,
    parameter int FRAC = 12
) (
    input logic            clk,
    input logic            rst,
    pid_engine_mc_if.slave bus
);
    localparam int CHW  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNTW = $clog2(W + 1);
    localparam logic [CHW:0]    N_CH_V   = (CHW + 1)'(N_CH);
    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(W - 1);

    typedef enum logic [2:0] {S_IDLE, S_ERR, S_PMUL, S_IMUL, S_DMUL, S_OUT} state_t;

    state_t                state_q, state_d;
    logic [CHW-1:0]        ch_q, ch_d;
    logic signed [W-1:0]   meas_q, meas_d;
    logic signed [W-1:0]   lat_xset_q, lat_xset_d, lat_kp_q, lat_kp_d;
    logic signed [W-1:0]   lat_ki_q, lat_ki_d, lat_kd_q, lat_kd_d;
    logic signed [W-1:0]   lat_prev_q, lat_prev_d;
    logic signed [W-1:0]   err_q, err_d, isum_q, isum_d, derr_q, derr_d;
    logic signed [2*W+1:0] bp_q, bp_d;
    logic signed [W:0]     mcand_q, mcand_d;
    logic [CNTW-1:0]       cnt_q, cnt_d;
    logic signed [W+1:0]   pterm_q, pterm_d, iterm_q, iterm_d, dterm_q, dterm_d;
    logic                  clr_pend_q, clr_pend_d;
    logic                  duty_vld_q, duty_vld_d;
    logic [CHW-1:0]        duty_ch_q, duty_ch_d;
    logic signed [W-1:0]   duty_q, duty_d;
    logic                  ch_err_q, ch_err_d;

    logic signed [W-1:0]   xset_q [N_CH], xset_d [N_CH];
    logic signed [W-1:0]   kp_q [N_CH], kp_d [N_CH];
    logic signed [W-1:0]   ki_q [N_CH], ki_d [N_CH];
    logic signed [W-1:0]   kd_q [N_CH], kd_d [N_CH];
    logic signed [W-1:0]   sumerr_q [N_CH], sumerr_d [N_CH];
    logic signed [W-1:0]   preverr_q [N_CH], preverr_d [N_CH];

    logic signed [W:0]     a_cur, a_nxt;
    logic signed [2*W+1:0] bp_step;
    logic signed [2*W-1:0] prod;
    logic signed [W+1:0]   term;
    logic signed [W-1:0]   err_v, sum_v, derr_v;
    logic                  meas_ok, cfg_ok, accept, inflight, clr_req, clr_hit, clr_now;
    logic [CHW-1:0]        infl_ch;

    function automatic logic signed [W+3:0] sx4(input logic signed [W-1:0] v);
        return {{4{v[W-1]}}, v};
    endfunction

    function automatic logic signed [W+3:0] sx2(input logic signed [W+1:0] v);
        return {{2{v[W+1]}}, v};
    endfunction

    function automatic logic signed [W-1:0] sat_w(input logic signed [W+3:0] x);
        if (x[W+3:W-1] == {5{x[W+3]}})
            return x[W-1:0];
        else if (x[W+3])
            return {1'b1, {(W-1){1'b0}}};
        else
            return {1'b0, {(W-1){1'b1}}};
    endfunction

    function automatic logic signed [W+1:0] sat_t(input logic signed [2*W-1:0] x);
        if (x[2*W-1:W+1] == {(W-1){x[2*W-1]}})
            return x[W+1:0];
        else if (x[2*W-1])
            return {1'b1, {(W+1){1'b0}}};
        else
            return {1'b0, {(W+1){1'b1}}};
    endfunction

    // Booth register layout: {A (W+1 bits), multiplier (W bits), q[-1]}.
    // The extra A bit absorbs A - M when M is the most negative gain.
    function automatic logic signed [2*W+1:0] booth_load(input logic signed [W-1:0] m);
        return {{(W+1){1'b0}}, m, 1'b0};
    endfunction

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        meas_d     = meas_q;
        lat_xset_d = lat_xset_q;
        lat_kp_d   = lat_kp_q;
        lat_ki_d   = lat_ki_q;
        lat_kd_d   = lat_kd_q;
        lat_prev_d = lat_prev_q;
        err_d      = err_q;
        isum_d     = isum_q;
        derr_d     = derr_q;
        bp_d       = bp_q;
        mcand_d    = mcand_q;
        cnt_d      = cnt_q;
        pterm_d    = pterm_q;
        iterm_d    = iterm_q;
        dterm_d    = dterm_q;
        clr_pend_d = clr_pend_q;
        duty_vld_d = 1'b0;
        duty_ch_d  = duty_ch_q;
        duty_d     = duty_q;
        ch_err_d   = 1'b0;
        xset_d     = xset_q;
        kp_d       = kp_q;
        ki_d       = ki_q;
        kd_d       = kd_q;
        sumerr_d   = sumerr_q;
        preverr_d  = preverr_q;
        clr_now    = 1'b0;

        a_cur = bp_q[2*W+1:W+1];
        case (bp_q[1:0])
            2'b01:   a_nxt = a_cur + mcand_q;
            2'b10:   a_nxt = a_cur - mcand_q;
            default: a_nxt = a_cur;
        endcase
        bp_step = {a_nxt[W], a_nxt, bp_q[W:1]};
        prod    = bp_step[2*W:1];
        term    = sat_t(prod >>> FRAC);

        err_v  = sat_w(sx4(meas_q) - sx4(lat_xset_q));
        sum_v  = sat_w(sx4(sumerr_q[ch_q]) + sx4(err_v));
        derr_v = sat_w(sx4(err_v) - sx4(lat_prev_q));

        meas_ok  = {1'b0, bus.meas_ch} < N_CH_V;
        cfg_ok   = {1'b0, bus.cfg_ch} < N_CH_V;
        accept   = (state_q == S_IDLE) && bus.meas_vld;
        infl_ch  = (state_q == S_IDLE) ? bus.meas_ch : ch_q;
        inflight = (state_q != S_IDLE) || (accept && meas_ok);
        clr_req  = bus.cfg_we && (bus.cfg_sel == 3'd4) && cfg_ok;
        clr_hit  = clr_req && inflight && (bus.cfg_ch == infl_ch);
        if (clr_hit)
            clr_pend_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (meas_ok) begin
                        ch_d       = bus.meas_ch;
                        meas_d     = bus.meas;
                        lat_xset_d = xset_q[bus.meas_ch];
                        lat_kp_d   = kp_q[bus.meas_ch];
                        lat_ki_d   = ki_q[bus.meas_ch];
                        lat_kd_d   = kd_q[bus.meas_ch];
                        lat_prev_d = preverr_q[bus.meas_ch];
                        state_d    = S_ERR;
                    end else begin
                        ch_err_d = 1'b1;
                    end
                end
            end
            S_ERR: begin
                err_d   = err_v;
                isum_d  = sum_v;
                derr_d  = derr_v;
                bp_d    = booth_load(err_v);
                mcand_d = {lat_kp_q[W-1], lat_kp_q};
                cnt_d   = CNT_LOAD;
                state_d = S_PMUL;
            end
            S_PMUL: begin
                bp_d  = bp_step;
                cnt_d = cnt_q - CNTW'(1);
                if (cnt_q == '0) begin
                    pterm_d = term;
                    bp_d    = booth_load(isum_q);
                    mcand_d = {lat_ki_q[W-1], lat_ki_q};
                    cnt_d   = CNT_LOAD;
                    state_d = S_IMUL;
                end
            end
            S_IMUL: begin
                bp_d  = bp_step;
                cnt_d = cnt_q - CNTW'(1);
                if (cnt_q == '0) begin
                    iterm_d = term;
                    bp_d    = booth_load(derr_q);
                    mcand_d = {lat_kd_q[W-1], lat_kd_q};
                    cnt_d   = CNT_LOAD;
                    state_d = S_DMUL;
                end
            end
            S_DMUL: begin
                bp_d  = bp_step;
                cnt_d = cnt_q - CNTW'(1);
                if (cnt_q == '0) begin
                    dterm_d = term;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                duty_d     = sat_w(sx2(pterm_q) + sx2(iterm_q) + sx2(dterm_q));
                duty_ch_d  = ch_q;
                duty_vld_d = 1'b1;
                clr_now    = clr_pend_q || clr_hit;
                sumerr_d[ch_q]  = clr_now ? '0 : isum_q;
                preverr_d[ch_q] = clr_now ? '0 : err_q;
                clr_pend_d = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A clear aimed at the in-flight channel is deferred to OUT via clr_pend.
        if (bus.cfg_we && cfg_ok) begin
            case (bus.cfg_sel)
                3'd0: xset_d[bus.cfg_ch] = bus.cfg_data;
                3'd1: kp_d[bus.cfg_ch]   = bus.cfg_data;
                3'd2: ki_d[bus.cfg_ch]   = bus.cfg_data;
                3'd3: kd_d[bus.cfg_ch]   = bus.cfg_data;
                3'd4: begin
                    if (!clr_hit) begin
                        sumerr_d[bus.cfg_ch]  = '0;
                        preverr_d[bus.cfg_ch] = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ch_q       <= '0;
            meas_q     <= '0;
            lat_xset_q <= '0;
            lat_kp_q   <= '0;
            lat_ki_q   <= '0;
            lat_kd_q   <= '0;
            lat_prev_q <= '0;
            err_q      <= '0;
            isum_q     <= '0;
            derr_q     <= '0;
            bp_q       <= '0;
            mcand_q    <= '0;
            cnt_q      <= '0;
            pterm_q    <= '0;
            iterm_q    <= '0;
            dterm_q    <= '0;
            clr_pend_q <= 1'b0;
            duty_vld_q <= 1'b0;
            duty_ch_q  <= '0;
            duty_q     <= '0;
            ch_err_q   <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                xset_q[i]    <= '0;
                kp_q[i]      <= '0;
                ki_q[i]      <= '0;
                kd_q[i]      <= '0;
                sumerr_q[i]  <= '0;
                preverr_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            meas_q     <= meas_d;
            lat_xset_q <= lat_xset_d;
            lat_kp_q   <= lat_kp_d;
            lat_ki_q   <= lat_ki_d;
            lat_kd_q   <= lat_kd_d;
            lat_prev_q <= lat_prev_d;
            err_q      <= err_d;
            isum_q     <= isum_d;
            derr_q     <= derr_d;
            bp_q       <= bp_d;
            mcand_q    <= mcand_d;
            cnt_q      <= cnt_d;
            pterm_q    <= pterm_d;
            iterm_q    <= iterm_d;
            dterm_q    <= dterm_d;
            clr_pend_q <= clr_pend_d;
            duty_vld_q <= duty_vld_d;
            duty_ch_q  <= duty_ch_d;
            duty_q     <= duty_d;
            ch_err_q   <= ch_err_d;
            xset_q     <= xset_d;
            kp_q       <= kp_d;
            ki_q       <= ki_d;
            kd_q       <= kd_d;
            sumerr_q   <= sumerr_d;
            preverr_q  <= preverr_d;
        end
    end

    assign bus.meas_rdy = (state_q == S_IDLE);
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.duty_vld = duty_vld_q;
    assign bus.duty_ch  = duty_ch_q;
    assign bus.duty     = duty_q;
    assign bus.ch_err   = ch_err_q;
endmodule

// File: tb/tb_pid_engine_mc.sv
// Scoreboard bench for pid_engine_mc: a 4-channel instance for the arithmetic
// and a 3-channel instance for out-of-range channel handling.
module tb_pid_engine_mc;
    localparam int W = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst3 = 1'b1;
    int   cyc = 0;
    int   n_run = 0;
    int   n_fail = 0;

    typedef struct {
        int ch;
        int duty;
        int acc;
    } exp_t;

    exp_t sbq[$];
    exp_t sbq3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pid_engine_mc_if #(.N_CH(4), .W(W)) bus ();
    pid_engine_mc_if #(.N_CH(3), .W(W)) bus3 ();

    pid_engine_mc #(.N_CH(4), .W(W), .FRAC(12)) dut  (.clk(clk), .rst(rst),  .bus(bus));
    pid_engine_mc #(.N_CH(3), .W(W), .FRAC(12)) dut3 (.clk(clk), .rst(rst3), .bus(bus3));

    task automatic check(input string name, input int act, input int req);
        n_run++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        n_run++;
        n_fail++;
        $display("FAIL %s: bound expired, expected completion", name);
    endtask

    // Monitors: every duty_vld must match the oldest expected result, 45 cycles after accept.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.duty_vld) begin
            if (sbq.size() == 0) begin
                n_run++;
                n_fail++;
                $display("FAIL unexpected_duty: got duty_vld ch %0d duty %0d, expected none",
                         bus.duty_ch, bus.duty);
            end else begin
                e = sbq.pop_front();
                check("duty", bus.duty, e.duty);
                check("duty_ch", int'(bus.duty_ch), e.ch);
                check("latency", cyc - e.acc, 45);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst3 && bus3.duty_vld) begin
            if (sbq3.size() == 0) begin
                n_run++;
                n_fail++;
                $display("FAIL unexpected_duty3: got duty_vld ch %0d duty %0d, expected none",
                         bus3.duty_ch, bus3.duty);
            end else begin
                e = sbq3.pop_front();
                check("duty3", bus3.duty, e.duty);
                check("duty_ch3", int'(bus3.duty_ch), e.ch);
                check("latency3", cyc - e.acc, 45);
            end
        end
    end

    task automatic cfg(input int ch, input int sel, input int d);
        bus.cfg_we   = 1'b1;
        bus.cfg_ch   = 2'(ch);
        bus.cfg_sel  = 3'(sel);
        bus.cfg_data = W'(d);
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge of cycle 1 after the accept.
    task automatic send(input int ch, input int m, input int exp_duty, input bit push);
        int k;
        bus.meas_ch  = 2'(ch);
        bus.meas     = W'(m);
        bus.meas_vld = 1'b1;
        k = 0;
        while (!bus.meas_rdy && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) begin
            fail_now("accept_timeout");
            bus.meas_vld = 1'b0;
        end else begin
            @(negedge clk);
            bus.meas_vld = 1'b0;
            if (push) sbq.push_back('{ch, exp_duty, cyc - 1});
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((sbq.size() != 0 || !bus.meas_rdy) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) fail_now("idle_timeout");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bus.meas_vld = 1'b0;  bus.meas_ch = '0;  bus.meas = '0;
        bus.cfg_we = 1'b0;    bus.cfg_ch = '0;   bus.cfg_sel = '0;  bus.cfg_data = '0;
        bus3.meas_vld = 1'b0; bus3.meas_ch = '0; bus3.meas = '0;
        bus3.cfg_we = 1'b0;   bus3.cfg_ch = '0;  bus3.cfg_sel = '0; bus3.cfg_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rst3 = 1'b0;
        @(negedge clk);

        check("rst_meas_rdy", bus.meas_rdy, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_duty_vld", bus.duty_vld, 0);
        check("rst_duty", bus.duty, 0);
        check("rst_duty_ch", int'(bus.duty_ch), 0);
        check("rst_ch_err", bus.ch_err, 0);

        // 3-channel build: out-of-range channel
        bus3.meas_ch = 2'd3;
        bus3.meas = W'(123);
        bus3.meas_vld = 1'b1;
        @(negedge clk);
        bus3.meas_vld = 1'b0;
        check("inv_ch_err_c1", bus3.ch_err, 1);
        check("inv_rdy_c1", bus3.meas_rdy, 1);
        @(negedge clk);
        check("inv_ch_err_c2", bus3.ch_err, 0);
        check("inv_rdy_c2", bus3.meas_rdy, 1);
        bus3.cfg_we = 1'b1; bus3.cfg_ch = 2'd2; bus3.cfg_sel = 3'd1; bus3.cfg_data = W'(4096);
        @(negedge clk);
        bus3.cfg_we = 1'b0;
        bus3.meas_ch = 2'd2; bus3.meas = W'(77); bus3.meas_vld = 1'b1;
        @(negedge clk);
        bus3.meas_vld = 1'b0;
        sbq3.push_back('{2, 77, cyc - 1});
        k = 0;
        while (sbq3.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) fail_now("dut3_timeout");

        // all gains zero
        send(0, 100, 0, 1); wait_idle();

        // Booth sign handling and saturation on ch0
        cfg(0, 1, -2048); send(0, -1000, 500, 1);  wait_idle();
        cfg(0, 1, -8192); send(0, 5000, -8192, 1); wait_idle();
        cfg(0, 1, 2048);  cfg(0, 0, -8192);
        send(0, 8191, 4095, 1); wait_idle();

        // ch1 proportional, plus a request while busy that must be ignored
        cfg(1, 0, 0); cfg(1, 1, 4096);
        send(1, 1000, 1000, 1); wait_idle();
        send(1, 1000, 1000, 1);
        repeat (9) @(negedge clk);
        bus.meas_ch = 2'd1; bus.meas = W'(50); bus.meas_vld = 1'b1;
        check("busy_rdy", bus.meas_rdy, 0);
        check("busy_busy", bus.busy, 1);
        @(negedge clk);
        bus.meas_vld = 1'b0;
        wait_idle();
        repeat (60) @(negedge clk);

        // ch2 integrator with clamping, then idle clear
        cfg(2, 2, 4096);
        send(2, 8191, 8191, 1);  wait_idle();
        send(2, 8191, 8191, 1);  wait_idle();
        send(2, -8192, -1, 1);   wait_idle();
        cfg(2, 4, 0);
        send(2, 5, 5, 1);        wait_idle();

        // ch3 derivative, with a clear during the second computation
        cfg(3, 3, 4096);
        send(3, 500, 500, 1);  wait_idle();
        send(3, 300, -200, 1);
        repeat (5) @(negedge clk);
        cfg(3, 4, 0);
        wait_idle();
        send(3, 300, 300, 1);  wait_idle();

        // reset in mid-computation
        send(1, 1000, 0, 0);
        repeat (18) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_duty", bus.duty, 0);
        check("mid_rst_duty_ch", int'(bus.duty_ch), 0);
        check("mid_rst_duty_vld", bus.duty_vld, 0);
        check("mid_rst_meas_rdy", bus.meas_rdy, 1);
        check("mid_rst_busy", bus.busy, 0);
        repeat (60) @(negedge clk);
        send(1, 1000, 0, 1); wait_idle();
        send(3, 300, 0, 1);  wait_idle();

        check("sb_drained", sbq.size(), 0);
        check("sb3_drained", sbq3.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/pid_engine_mc.md
# pid_engine_mc

Multi-channel, parametrised PID arithmetic engine for the motor/servo control loop. It holds per-channel setpoint, gains and loop state, and services one measurement at a time. For each measurement it computes P, I and D terms with a shared sequential radix-2 Booth multiplier, then emits a saturated duty value tagged with its channel. Setpoint and gain loading moves to a register-write port; the block has no direct EEPROM access. Integrator anti-windup and per-channel state clear are new features.

## Interface
- N_CH, 4: number of channels (≥1); CHW = max(1, $clog2(N_CH))
- W, 14: signed width of measurement, setpoint, gains, error, integrator and duty
- FRAC, 12: fractional bits of gains; each product is arithmetically shifted right by FRAC
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- meas_vld  in  1  measurement request
- meas_ch  in  CHW  channel of request
- meas  in  W  signed measurement
- meas_rdy  out  1  engine idle; request accepted when meas_vld & meas_rdy
- cfg_we  in  1  config write strobe, accepted any cycle
- cfg_ch  in  CHW  target channel
- cfg_sel  in  3  0 Xset, 1 Kp, 2 Ki, 3 Kd, 4 clear SumErr+PrevErr, others ignored
- cfg_data  in  W  signed write data; ignored for sel 4
- duty_vld  out  1  one-cycle result strobe
- duty_ch  out  CHW  channel of result
- duty  out  W  signed saturated duty
- ch_err  out  1  one-cycle pulse: request had meas_ch ≥ N_CH
- busy  out  1  equals ~meas_rdy

## Operation
- Storage per channel: Xset, Kp, Ki, Kd, SumErr, PrevErr (all W bits). All reset to 0.
- sat(x) clamps x to [-2^(W-1), 2^(W-1)-1].
- IDLE: meas_rdy=1.
  - On accept with a valid channel: latch ch, meas, Xset[ch], Kp[ch], Ki[ch], Kd[ch] and PrevErr[ch], then go to ERR. Later cfg writes do not affect this computation.
  - On accept with ch ≥ N_CH: consume the request, pulse ch_err next cycle, stay in IDLE, produce no duty.
- ERR (1 cycle):
  - err = sat(meas − Xset) at W+1 bits.
  - sum = sat(SumErr[ch] + err).
  - derr = sat(err − PrevErr).
  - Go to PMUL.
- PMUL / IMUL / DMUL (W cycles each): radix-2 Booth multiply, one bit pair per cycle.
  - Multiplicands are Kp·err, Ki·sum and Kd·derr respectively.
  - Each produces an exact 2W-bit product. Term = product >>> FRAC, kept at W+2 bits with saturation.
- OUT (1 cycle):
  - duty ← sat(P+I+D), summed at W+4 bits.
  - SumErr[ch] ← sum and PrevErr[ch] ← err, unless a clear for ch arrived during this computation, in which case both are written 0.
  - Return to IDLE.
- duty, duty_ch and duty_vld are registered. duty/duty_ch hold their value until the next result.
- cfg write to sel 0–3 takes effect at the next clock edge. cfg_ch ≥ N_CH is ignored.
- Clear (sel 4) on an idle channel zeroes SumErr and PrevErr at the next edge.
- Clear on the in-flight channel (any cycle from accept through OUT) sets a pending flag. OUT then writes 0 instead of sum/err. That computation's duty is still output unchanged.
- Reset in mid-operation: state goes to IDLE, all storage and outputs go to 0, and any in-flight result is discarded.
- Reset values: meas_rdy=1, busy=0, duty_vld=0, duty=0, duty_ch=0, ch_err=0.

## Timing
- Accept edge is cycle 0. ERR is cycle 1. PMUL is cycles 2..W+1, IMUL is W+2..2W+1, DMUL is 2W+2..3W+1, OUT is 3W+2.
- duty_vld is high in cycle 3W+3 (45 for W=14). meas_rdy is also 1 in that cycle, so back-to-back throughput is one result per 3W+3 cycles.
- meas_vld while meas_rdy=0 is ignored. It is not queued, and the requester must hold it.
- ch_err is high in cycle 1 after an invalid accept. meas_rdy stays 1 throughout.
- A cfg write and an OUT writeback to the same channel in the same cycle never collide: cfg cannot touch SumErr/PrevErr except via clear, and clear wins.

## Test plan
- Reset, then meas_vld with ch0=100 and all gains 0 → meas_rdy=1 after reset; duty_vld only in cycle 45 with duty=0, duty_ch=0.
- Ch1: Xset=0, Kp=4096, meas=1000, sent twice → duty=1000 both times. Then meas_vld asserted in cycle 10 → ignored, no extra duty_vld.
- Ch2: Ki=4096 only, meas=8191 twice → duty 8191, 8191 (SumErr clamps at 8191). Then meas=−8192 → SumErr=−1, duty=−1.
- Ch3: Kd=4096 only, meas 500 then 300 → duty 500 then −200. Clear ch3 during the second computation → duty still −200; next meas=300 → duty 300.
- Booth signs: Kp=−2048, meas=−1000 → duty=500. Kp=−8192, meas=5000 → −10000 saturates to duty=−8192. Xset=−8192, meas=8191 → err saturates to 8191.
- N_CH=3 build: meas_ch=3 → ch_err pulse in cycle 1, no duty_vld, meas_rdy stays 1. Assert rst at cycle 20 of a computation → no duty_vld, all outputs 0, stored gains cleared.
